// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder: protocol bytes,
// FSM state encoding, decoded command kinds and the opcode decoder.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 24;
  // Block count needs one extra bit so that a count byte of 0 can mean 256.
  localparam int unsigned CNT_W  = 9;

  localparam logic [BYTE_W-1:0] OPC_WRITE = 8'h57; // 'W'
  localparam logic [BYTE_W-1:0] OPC_READ  = 8'h52; // 'R'
  localparam logic [BYTE_W-1:0] OPC_BLOCK = 8'h42; // 'B'
  localparam logic [BYTE_W-1:0] OPC_IDENT = 8'h49; // 'I'
  localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;
  localparam logic [BYTE_W-1:0] NAK_BYTE  = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR_H   = 4'd1,
    ST_ADDR_M   = 4'd2,
    ST_ADDR_L   = 4'd3,
    ST_ARG      = 4'd4,
    ST_MEM_REQ  = 4'd5,
    ST_MEM_WAIT = 4'd6,
    ST_TX_REQ   = 4'd7,
    ST_TX_WAIT  = 4'd8
  } state_e;

  // Commands that carry an address; CMD_NONE covers identify and NAK replies.
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_BLOCK = 2'd3
  } cmd_e;

  // Map an opcode byte onto the memory command it starts.
  function automatic cmd_e decode_opcode(input logic [BYTE_W-1:0] opc);
    cmd_e cmd;
    cmd = CMD_NONE;
    if (opc == OPC_WRITE) cmd = CMD_WRITE;
    else if (opc == OPC_READ) cmd = CMD_READ;
    else if (opc == OPC_BLOCK) cmd = CMD_BLOCK;
    return cmd;
  endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: byte-oriented command parser sitting between a UART
// and a 24-bit byte-addressed memory port. Frames are an opcode, three
// address bytes (MSB first) and, for write/block-read, one argument byte.
//
// Ports:
//   clk, reset             - system clock, asynchronous active-high reset
//   rx_data, rx_ready      - received byte and its one-cycle strobe
//   tx_data, tx_req        - byte to send and its one-cycle start strobe
//   tx_ready               - one-cycle strobe when the UART finished a byte
//   mem_addr, mem_wdata    - memory address and write data
//   mem_wr, mem_rd         - one-cycle memory request strobes
//   mem_rdata, mem_done    - read data and completion strobe
//   busy                   - high whenever the FSM is not idle
//
// Build option: define CMD_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES clocks without a received byte. Without it a partial frame
// waits indefinitely.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]      ID_BYTE        = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_ready,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_req,
  input  logic               tx_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BYTE_W-1:0]  mem_wdata,
  output logic               mem_wr,
  output logic               mem_rd,
  input  logic [BYTE_W-1:0]  mem_rdata,
  input  logic               mem_done,
  output logic               busy
);

  // Zero would make every partial frame expire immediately.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q,   state_d;
  cmd_e                cmd_q,     cmd_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [BYTE_W-1:0]   wdata_q,   wdata_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic [CNT_W-1:0]    count_q,   count_d;
  logic                tx_req_q,  tx_req_d;
  logic                mem_wr_q,  mem_wr_d;
  logic                mem_rd_q,  mem_rd_d;
  logic                busy_q,    busy_d;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0]    tmo_q,     tmo_d;
  logic                in_frame;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    count_d   = count_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_ready) begin
          cmd_d = decode_opcode(rx_data);
          if (cmd_d != CMD_NONE) begin
            state_d = ST_ADDR_H;
          end else begin
            // Identify and unknown opcodes answer immediately.
            tx_data_d = (rx_data == OPC_IDENT) ? ID_BYTE : NAK_BYTE;
            state_d   = ST_TX_REQ;
          end
        end
      end

      ST_ADDR_H: begin
        if (rx_ready) begin
          addr_d[23:16] = rx_data;
          state_d       = ST_ADDR_M;
        end
      end

      ST_ADDR_M: begin
        if (rx_ready) begin
          addr_d[15:8] = rx_data;
          state_d      = ST_ADDR_L;
        end
      end

      ST_ADDR_L: begin
        if (rx_ready) begin
          addr_d[7:0] = rx_data;
          state_d     = (cmd_q == CMD_READ) ? ST_MEM_REQ : ST_ARG;
        end
      end

      ST_ARG: begin
        if (rx_ready) begin
          if (cmd_q == CMD_WRITE) begin
            wdata_d = rx_data;
          end else begin
            // A count byte of zero requests a full 256-byte block.
            count_d = (rx_data == 8'h00) ? CNT_W'(256) : CNT_W'(rx_data);
          end
          state_d = ST_MEM_REQ;
        end
      end

      ST_MEM_REQ: begin
        state_d = ST_MEM_WAIT;
      end

      ST_MEM_WAIT: begin
        if (mem_done) begin
          tx_data_d = (cmd_q == CMD_WRITE) ? ACK_BYTE : mem_rdata;
          state_d   = ST_TX_REQ;
        end
      end

      ST_TX_REQ: begin
        state_d = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        if (tx_ready) begin
          if ((cmd_q == CMD_BLOCK) && (count_q > CNT_W'(1))) begin
            // Next byte of a block read; the address wraps at 24 bits.
            count_d = count_q - CNT_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_MEM_REQ;
          end else begin
            count_d = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef CMD_TIMEOUT_EN
    // Inter-byte timeout while a frame is partially received; a byte
    // arriving in the expiry cycle takes precedence.
    in_frame = (state_q == ST_ADDR_H) || (state_q == ST_ADDR_M) ||
               (state_q == ST_ADDR_L) || (state_q == ST_ARG);
    tmo_d    = '0;
    if (in_frame && !rx_ready) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
`endif

    // Strobes are decoded from the next state so they appear exactly in
    // the cycle the FSM sits in the request state.
    tx_req_d = (state_d == ST_TX_REQ);
    mem_wr_d = (state_d == ST_MEM_REQ) && (cmd_d == CMD_WRITE);
    mem_rd_d = (state_d == ST_MEM_REQ) && (cmd_d != CMD_WRITE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      count_q   <= '0;
      tx_req_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      count_q   <= count_d;
      tx_req_q  <= tx_req_d;
      mem_wr_q  <= mem_wr_d;
      mem_rd_q  <= mem_rd_d;
      busy_q    <= busy_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_req    = tx_req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: a command-level model predicts
// the ordered memory/transmit events, reactive memory and UART responders
// answer with random latencies and inject ignorable strobes, and a compare
// process checks every DUT pulse against the prediction.
module tb_uart_cmd_responder;

  localparam int K_WR = 0, K_RD = 1, K_TX = 2;
  localparam int TRIG_RX = 0, TRIG_DONE = 1, TRIG_TXR = 2;

  typedef struct {
    int          kind;
    logic [23:0] addr;
    logic [7:0]  data;
    int          trig;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        drv_rx = 1'b0;
  logic [7:0]  drv_data = 8'h00;
  logic        junk_rx = 1'b0;
  logic [7:0]  junk_data = 8'h00;
  logic        resp_done = 1'b0, spur_done = 1'b0;
  logic        resp_txr = 1'b0, spur_txr = 1'b0;
  logic        hold_mem = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;

  logic        rx_ready, tx_ready, mem_done;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data, mem_wdata;
  logic        tx_req, mem_wr, mem_rd, busy;
  logic [23:0] mem_addr;

  assign rx_ready = drv_rx | junk_rx;
  assign rx_data  = junk_rx ? junk_data : drv_data;
  assign mem_done = resp_done | spur_done;
  assign tx_ready = resp_txr | spur_txr;

  uart_cmd_responder #(.TIMEOUT_CYCLES(100), .ID_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  ev_t exp_q[$];
  logic [7:0] model_mem [logic [23:0]];
  logic [7:0] resp_mem  [logic [23:0]];

  // Observations of the DUT used by the literal pin checks.
  logic [23:0] obs_wr_addr = '0, obs_rd_addr = '0;
  logic [7:0]  obs_wdata = '0, obs_tx = '0;
  int          obs_rd_cnt = 0, obs_tx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] model_rd(input logic [23:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] resp_rd(input logic [23:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_val(a);
  endfunction

  function automatic bit is_mem_op(input logic [7:0] op);
    return (op == 8'h57) || (op == 8'h52) || (op == 8'h42);
  endfunction

  // Command-level model: the ordered events one command must produce.
  task automatic model_cmd(input logic [7:0] op, input logic [23:0] a, input logic [7:0] arg);
    int n;
    logic [23:0] ai;
    case (op)
      8'h57: begin
        exp_q.push_back('{K_WR, a, arg, TRIG_RX});
        model_mem[a] = arg;
        exp_q.push_back('{K_TX, 24'h0, 8'h06, TRIG_DONE});
      end
      8'h52: begin
        exp_q.push_back('{K_RD, a, 8'h00, TRIG_RX});
        exp_q.push_back('{K_TX, 24'h0, model_rd(a), TRIG_DONE});
      end
      8'h42: begin
        n = (arg == 8'h00) ? 256 : int'(arg);
        for (int i = 0; i < n; i++) begin
          ai = a + 24'(i);
          exp_q.push_back('{K_RD, ai, 8'h00, (i == 0) ? TRIG_RX : TRIG_TXR});
          exp_q.push_back('{K_TX, 24'h0, model_rd(ai), TRIG_DONE});
        end
      end
      8'h49:   exp_q.push_back('{K_TX, 24'h0, 8'hA5, TRIG_RX});
      default: exp_q.push_back('{K_TX, 24'h0, 8'h15, TRIG_RX});
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input int extra);
    repeat (extra) @(posedge clk);
    @(posedge clk); #1;
    drv_rx = 1'b1; drv_data = b;
    @(posedge clk); #1;
    drv_rx = 1'b0; drv_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [23:0] a, input logic [7:0] arg);
    send_byte(op, $urandom_range(0, 2));
    if (is_mem_op(op)) begin
      send_byte(a[23:16], $urandom_range(0, 2));
      send_byte(a[15:8],  $urandom_range(0, 2));
      send_byte(a[7:0],   $urandom_range(0, 2));
      if (op != 8'h52) send_byte(arg, $urandom_range(0, 2));
    end
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    @(negedge clk);
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, limit);
    end
    check("events_drained", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [23:0] a, input logic [7:0] arg);
    model_cmd(op, a, arg);
    send_frame(op, a, arg);
    wait_idle(6000);
  endtask

  // Compare process state.
  int last_rx = -10, last_done = -10, busy_chk_cyc = -1;
  logic tx_pending = 1'b0;
  logic [7:0] tx_held = 8'h00;

  task automatic do_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == K_TX) check("tx_data", 32'(tx_data), 32'(e.data));
      else              check("mem_addr", 32'(mem_addr), 32'(e.addr));
      if (kind == K_WR) check("mem_wdata", 32'(mem_wdata), 32'(e.data));
      if (e.trig == TRIG_RX)        check("latency_after_rx", 32'(cyc), 32'(last_rx + 1));
      else if (e.trig == TRIG_DONE) check("latency_after_done", 32'(cyc), 32'(last_done + 1));
    end
    if (kind == K_WR) begin obs_wr_addr = mem_addr; obs_wdata = mem_wdata; end
    if (kind == K_RD) begin obs_rd_addr = mem_addr; obs_rd_cnt++; end
    if (kind == K_TX) begin obs_tx = tx_data; obs_tx_cnt++; end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("wr_rd_exclusive", 32'(mem_wr & mem_rd), 0);
        if (cyc == busy_chk_cyc) check("busy_after_final_tx", 32'(busy), 0);
        if (tx_pending) check("tx_data_stable", 32'(tx_data), 32'(tx_held));
        if (mem_wr) do_event(K_WR);
        if (mem_rd) do_event(K_RD);
        if (tx_req) begin
          do_event(K_TX);
          tx_pending = 1'b1;
          tx_held    = tx_data;
        end
        if (drv_rx)    last_rx   = cyc;
        if (resp_done) last_done = cyc;
        if (resp_txr) begin
          tx_pending = 1'b0;
          if (exp_q.size() == 0) busy_chk_cyc = cyc + 1;
        end
      end else begin
        tx_pending = 1'b0;
      end
    end
  end

  // Memory responder: random latency, stray tx_ready while the DUT waits.
  initial begin : mem_resp
    logic [23:0] a;
    logic [7:0]  rd;
    int k;
    forever begin
      @(negedge clk);
      if (!reset && !hold_mem && (mem_wr || mem_rd)) begin
        a = mem_addr;
        if (mem_wr) resp_mem[a] = mem_wdata;
        rd = resp_rd(a);
        k = $urandom_range(1, 4);
        for (int i = 1; i <= k; i++) begin
          @(posedge clk); #1;
          spur_txr  = (i < k) && ($urandom_range(0, 2) == 0);
          resp_done = (i == k);
          mem_rdata = (i == k) ? rd : 8'($urandom);
        end
        @(posedge clk); #1;
        spur_txr = 1'b0; resp_done = 1'b0; mem_rdata = 8'($urandom);
      end
    end
  end

  // UART responder: random latency, stray mem_done and rx bytes meanwhile.
  initial begin : uart_resp
    int k;
    forever begin
      @(negedge clk);
      if (!reset && tx_req) begin
        k = $urandom_range(1, 5);
        for (int i = 1; i <= k; i++) begin
          @(posedge clk); #1;
          junk_rx   = (i < k) && ($urandom_range(0, 1) == 0);
          junk_data = 8'($urandom);
          spur_done = (i < k) && ($urandom_range(0, 2) == 0);
          resp_txr  = (i == k);
        end
        @(posedge clk); #1;
        junk_rx = 1'b0; spur_done = 1'b0; resp_txr = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int rd0, tx0, r;
    logic [7:0]  op, arg;
    logic [23:0] a;

    model_mem[24'hFFFFFF] = 8'h5C;
    resp_mem[24'hFFFFFF]  = 8'h5C;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_tx_req", 32'(tx_req), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single write.
    run_cmd(8'h57, 24'h001234, 8'hAB);
    check("pin_wr_addr", 32'(obs_wr_addr), 32'h001234);
    check("pin_wr_data", 32'(obs_wdata), 32'hAB);
    check("pin_ack", 32'(obs_tx), 32'h06);

    // Read at top of address space, then a wrapping block read.
    run_cmd(8'h52, 24'hFFFFFF, 8'h00);
    check("pin_rd_addr", 32'(obs_rd_addr), 32'hFFFFFF);
    check("pin_rd_data", 32'(obs_tx), 32'h5C);
    rd0 = obs_rd_cnt; tx0 = obs_tx_cnt;
    run_cmd(8'h42, 24'hFFFFFF, 8'h02);
    check("pin_wrap_rd_cnt", 32'(obs_rd_cnt - rd0), 2);
    check("pin_wrap_tx_cnt", 32'(obs_tx_cnt - tx0), 2);
    check("pin_wrap_addr", 32'(obs_rd_addr), 32'h000000);
    check("pin_wrap_data", 32'(obs_tx), 32'h3C);

    // NAK and identify.
    run_cmd(8'h3F, 24'h0, 8'h00);
    check("pin_nak", 32'(obs_tx), 32'h15);
    run_cmd(8'h49, 24'h0, 8'h00);
    check("pin_ident", 32'(obs_tx), 32'hA5);

    // Full 256-byte block.
    rd0 = obs_rd_cnt; tx0 = obs_tx_cnt;
    run_cmd(8'h42, 24'h000000, 8'h00);
    check("pin_blk256_rd_cnt", 32'(obs_rd_cnt - rd0), 256);
    check("pin_blk256_tx_cnt", 32'(obs_tx_cnt - tx0), 256);
    check("pin_blk256_last_addr", 32'(obs_rd_addr), 32'h0000FF);

`ifdef CMD_TIMEOUT_EN
    // Partial frame abandoned after 100 idle cycles.
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    repeat (99) @(posedge clk);
    @(negedge clk);
    check("busy_before_expiry", 32'(busy), 1);
    @(negedge clk);
    check("busy_after_expiry", 32'(busy), 0);
    run_cmd(8'h49, 24'h0, 8'h00);
    check("pin_ident_after_timeout", 32'(obs_tx), 32'hA5);
    // Byte landing exactly on the expiry cycle is accepted.
    model_cmd(8'h57, 24'h001234, 8'hAB);
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'h12, 98);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    wait_idle(200);
    check("pin_expiry_win_addr", 32'(obs_wr_addr), 32'h001234);
`else
    // Partial frame waits indefinitely, then completes.
    model_cmd(8'h57, 24'h001234, 8'h6D);
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("busy_partial_frame", 32'(busy), 1);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h6D, 0);
    wait_idle(200);
    check("pin_late_wr_data", 32'(obs_wdata), 32'h6D);
`endif

    // Reset while a read waits for memory.
    hold_mem = 1'b1;
    exp_q.push_back('{K_RD, 24'hABCDEF, 8'h00, TRIG_RX});
    send_frame(8'h52, 24'hABCDEF, 8'h00);
    repeat (3) @(posedge clk);
    check("rd_issued_before_reset", 32'(exp_q.size()), 0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_req", 32'(tx_req), 0);
    check("mid_rst_mem_rd", 32'(mem_rd), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_mem_wdata", 32'(mem_wdata), 0);
    check("mid_rst_mem_addr", 32'(mem_addr), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    hold_mem = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_after_reset", 32'(busy), 0);
    run_cmd(8'h49, 24'h0, 8'h00);
    check("pin_ident_after_reset", 32'(obs_tx), 32'hA5);

    // Randomized command stream.
    for (int c = 0; c < 40; c++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      op = 8'h57;
      else if (r <= 4) op = 8'h52;
      else if (r <= 6) op = 8'h42;
      else if (r == 7) op = 8'h49;
      else begin
        do op = 8'($urandom); while (is_mem_op(op) || op == 8'h49);
      end
      a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3)) : 24'($urandom);
      arg = (op == 8'h42) ? 8'($urandom_range(1, 5)) : 8'($urandom);
      run_cmd(op, a, arg);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
